pn_scheduler: RTL and testbench
===============================

Name: pn_scheduler

Overview:
Physical-neuron controller that owns N soma instances.
- Loads each soma's 32-bit configuration word through a valid/ready config port.
- Sequences enable/kill of the somas over a run.
- Round-robin arbitrates their spike events into one valid/ready output stream for the downstream router.
- Sits between the host/config bus and the soma array.

Parameters:
- N_NEURON, 4, number of soma slots controlled (2..16).
- IDX_W, $clog2(N_NEURON), neuron index width.
- TIME_W, 16, spike time width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- cfg_valid  input  1  config word valid
- cfg_ready  output  1  config word accepted when high with cfg_valid
- cfg_idx  input  IDX_W  target neuron slot
- cfg_data  input  32  {V_th[31:24], V_leak[23:16], refr_time[15:8], axon_delay_hi[7:0]}
- cfg_last  input  1  last word of the config burst
- start  input  1  single-cycle run request
- stop  input  1  single-cycle stop request
- nrn_en  output  N_NEURON  per-soma enable
- nrn_kill  output  N_NEURON  per-soma kill pulse
- nrn_wdata  output  32*N_NEURON  per-soma W_DATA (slot i at [32i+31:32i])
- nrn_spike_vld  input  N_NEURON  soma i holds a spike, held until acked
- nrn_spike_time  input  TIME_W*N_NEURON  spike time per soma
- nrn_spike_ack  output  N_NEURON  one-hot grant/ack, one cycle
- out_valid  output  1  spike event valid
- out_ready  input  1  downstream accepts
- out_idx  output  IDX_W  source neuron
- out_time  output  TIME_W  spike time
- busy  output  1  state != IDLE
- cfg_err  output  1  sticky: write to slot >= N_NEURON

Behaviour:
- Reset values (asynchronous): all outputs 0; internal regs cleared, including cfg_loaded mask, RR pointer and output register; state IDLE. Reset mid-run drops any buffered event.
- FSM states: IDLE, CFG, RUN, DRAIN.
  - IDLE→CFG: cfg_valid.
  - IDLE→RUN: start && cfg_loaded != 0. start with an empty mask is ignored.
  - CFG→IDLE: accepted word with cfg_last.
  - RUN→DRAIN: stop.
  - DRAIN→IDLE: out_valid == 0.
  - stop in IDLE/CFG is ignored. start and stop in the same cycle in IDLE: start wins. In RUN, start is ignored.
- Config:
  - cfg_ready = 1 in IDLE and CFG, 0 otherwise. The IDLE-cycle word is accepted.
  - An accepted word is written to nrn_wdata[cfg_idx] and sets cfg_loaded[cfg_idx]. Visible on nrn_wdata the next cycle.
  - cfg_idx >= N_NEURON: data dropped, cfg_err set (cleared only by reset).
  - Rewriting a slot overwrites it.
- Run:
  - nrn_en = cfg_loaded, registered. Asserted the cycle after the RUN entry edge.
  - Entering DRAIN: nrn_en = 0, and nrn_kill = cfg_loaded for exactly one cycle.
  - No further grants are issued in DRAIN.
- Arbitration (RUN only):
  - Grant allowed when !out_valid || out_ready.
  - Winner = first set nrn_spike_vld bit at or after rr_ptr, wrapping.
  - Same cycle: nrn_spike_ack[winner] = 1; out register loads {winner, time}, valid next cycle.
  - rr_ptr ← winner+1 mod N_NEURON.
  - Full throughput: one event per cycle with out_ready held high.
  - out_* stable while out_valid && !out_ready.
- Latency: spike_vld to out_valid is 1 cycle when the output register is free.

Optional Feature:
- PN_SCHED_TIMESTAMP_EN
  - Defined: TIME_W-bit run counter, cleared on RUN entry, +1 per RUN cycle, wrapping. out_time = nrn_spike_time[winner] + counter (mod 2^TIME_W), captured at grant.
  - Undefined: out_time = raw nrn_spike_time[winner]; no counter.

Decomposition:
- Package pn_pkg:
  - state enum (IDLE, CFG, RUN, DRAIN)
  - cfg field offsets/widths: VTH_MSB=31, VLEAK_MSB=23, REFR_MSB=15, AXD_MSB=7
  - TIME_W default
- One sub-module: rr_arbiter (N-bit req, pointer in, one-hot grant + encoded index out; combinational pick, pointer update in parent).

Test Plan:
- Config slots 0..3 with 0x0A050308+i, cfg_last on slot 3 → nrn_wdata[i] matches, cfg_loaded=4'hF, return to IDLE; write idx 5 (N=8 off, N=4) → cfg_err=1, no slot changed.
- start with empty mask → stays IDLE, nrn_en=0. After config, start → nrn_en=4'hF one cycle later, busy=1.
- All four spike_vld high, times 10,20,30,40, out_ready=1 → out_idx 0,1,2,3 on consecutive cycles, one ack each, rr_ptr wraps to 0.
- out_ready=0 for 5 cycles with slot 2 valid → out_valid held, out_idx=2 stable, no further acks; release → next grant the following cycle.
- stop during RUN with event buffered → nrn_en=0, nrn_kill=4'hF one cycle, DRAIN until event consumed, then IDLE.
- PN_SCHED_TIMESTAMP_EN: spike time 0xFFF0 granted at counter 0x0020 → out_time=0x0010 (wrap).

Source files
------------

// File: rtl/pn_pkg.sv
// Shared types and constants for the physical-neuron scheduler.
package pn_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCfg   = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } pn_state_e;

  localparam int unsigned CFG_W          = 32;
  localparam int unsigned CFG_FIELD_W    = 8;
  localparam int unsigned VTH_MSB        = 31;
  localparam int unsigned VLEAK_MSB      = 23;
  localparam int unsigned REFR_MSB       = 15;
  localparam int unsigned AXD_MSB        = 7;
  localparam int unsigned TIME_W_DEFAULT = 16;

  function automatic logic [CFG_FIELD_W-1:0] cfg_vth(input logic [CFG_W-1:0] w);
    return w[VTH_MSB -: CFG_FIELD_W];
  endfunction

  function automatic logic [CFG_FIELD_W-1:0] cfg_vleak(input logic [CFG_W-1:0] w);
    return w[VLEAK_MSB -: CFG_FIELD_W];
  endfunction

  function automatic logic [CFG_FIELD_W-1:0] cfg_refr(input logic [CFG_W-1:0] w);
    return w[REFR_MSB -: CFG_FIELD_W];
  endfunction

  function automatic logic [CFG_FIELD_W-1:0] cfg_axd(input logic [CFG_W-1:0] w);
    return w[AXD_MSB -: CFG_FIELD_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!any && req[j] && (j == (int'(ptr) + k) % int'(N))) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pn_scheduler.sv
// Soma-array controller: config load, run enable/kill sequencing, spike arbitration.
// Optional build macro PN_SCHED_TIMESTAMP_EN adds a run-relative offset to out_time.
module pn_scheduler
  import pn_pkg::*;
#(
  parameter int unsigned N_NEURON = 4,
  parameter int unsigned IDX_W    = $clog2(N_NEURON),
  parameter int unsigned TIME_W   = TIME_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic [CFG_W-1:0]             cfg_data,
  input  logic                         cfg_last,
  input  logic                         start,
  input  logic                         stop,
  output logic [N_NEURON-1:0]          nrn_en,
  output logic [N_NEURON-1:0]          nrn_kill,
  output logic [CFG_W*N_NEURON-1:0]    nrn_wdata,
  input  logic [N_NEURON-1:0]          nrn_spike_vld,
  input  logic [TIME_W*N_NEURON-1:0]   nrn_spike_time,
  output logic [N_NEURON-1:0]          nrn_spike_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_idx,
  output logic [TIME_W-1:0]            out_time,
  output logic                         busy,
  output logic                         cfg_err
);

  pn_state_e             state_q, state_d;
  logic [N_NEURON-1:0]   cfg_loaded_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic                  cfg_acc, cfg_in_range;
  logic [N_NEURON-1:0]   arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any, grant_en;
  logic [TIME_W-1:0]     sel_time, stamp_time;

  rr_arbiter #(
    .N     (N_NEURON),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (nrn_spike_vld),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign cfg_acc       = cfg_valid && cfg_ready;
  assign cfg_in_range  = int'(cfg_idx) < int'(N_NEURON);
  assign grant_en      = (state_q == StRun) && (!out_valid || out_ready) && arb_any;
  assign nrn_spike_ack = grant_en ? arb_grant : '0;

  always_comb begin
    sel_time = '0;
    for (int i = 0; i < int'(N_NEURON); i++) begin
      if (arb_idx == IDX_W'(i)) sel_time = nrn_spike_time[TIME_W*i +: TIME_W];
    end
  end

`ifdef PN_SCHED_TIMESTAMP_EN
  logic [TIME_W-1:0] run_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
    end else if (state_q != StRun && state_d == StRun) begin
      run_cnt_q <= '0;
    end else if (state_q == StRun) begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end
  end

  assign stamp_time = sel_time + run_cnt_q;
`else
  assign stamp_time = sel_time;
`endif

  // A lone last word taken in IDLE completes its burst without visiting CFG.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && (|cfg_loaded_q)) state_d = StRun;
        else if (cfg_valid && !cfg_last) state_d = StCfg;
      end
      StCfg:   if (cfg_valid && cfg_last) state_d = StIdle;
      StRun:   if (stop) state_d = StDrain;
      StDrain: if (!out_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cfg_ready    <= 1'b0;
      busy         <= 1'b0;
      nrn_en       <= '0;
      nrn_kill     <= '0;
      nrn_wdata    <= '0;
      cfg_loaded_q <= '0;
      cfg_err      <= 1'b0;
      rr_ptr_q     <= '0;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_time     <= '0;
    end else begin
      state_q   <= state_d;
      cfg_ready <= (state_d == StIdle) || (state_d == StCfg);
      busy      <= (state_d != StIdle);
      nrn_en    <= (state_d == StRun) ? cfg_loaded_q : '0;
      nrn_kill  <= (state_q == StRun && state_d == StDrain) ? cfg_loaded_q : '0;

      if (cfg_acc) begin
        if (cfg_in_range) begin
          for (int i = 0; i < int'(N_NEURON); i++) begin
            if (cfg_idx == IDX_W'(i)) begin
              nrn_wdata[CFG_W*i +: CFG_W] <= cfg_data;
              cfg_loaded_q[i]             <= 1'b1;
            end
          end
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (grant_en) begin
        out_valid <= 1'b1;
        out_idx   <= arb_idx;
        out_time  <= stamp_time;
        rr_ptr_q  <= IDX_W'((int'(arb_idx) + 1) % int'(N_NEURON));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pn_scheduler.sv
// Bench for pn_scheduler: config table, hand-written corner sequences, random run vs model.
module tb_pn_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_valid = 1'b0, cfg_last = 1'b0, start = 1'b0, stop = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic [31:0]     cfg_data = '0;
  logic            cfg_ready, out_valid, busy, cfg_err;
  logic            out_ready = 1'b0;
  logic [N-1:0]    nrn_en, nrn_kill, nrn_spike_ack;
  logic [N-1:0]    nrn_spike_vld = '0;
  logic [32*N-1:0] nrn_wdata;
  logic [TW*N-1:0] nrn_spike_time = '0;
  logic [IW-1:0]   out_idx;
  logic [TW-1:0]   out_time;

  // Second instance with a non-power-of-two slot count so an out-of-range index exists.
  logic         c5_valid = 1'b0, c5_last = 1'b0, c5_start = 1'b0;
  logic [2:0]   c5_idx = '0;
  logic [31:0]  c5_data = '0;
  logic         c5_ready, c5_ov, c5_busy, c5_err;
  logic [4:0]   c5_en, c5_kill, c5_ack;
  logic [159:0] c5_wdata;
  logic [2:0]   c5_oidx;
  logic [15:0]  c5_otime;

  always #5 clk = ~clk;

  pn_scheduler #(.N_NEURON(N), .IDX_W(IW), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .start(start), .stop(stop), .nrn_en(nrn_en),
    .nrn_kill(nrn_kill), .nrn_wdata(nrn_wdata), .nrn_spike_vld(nrn_spike_vld),
    .nrn_spike_time(nrn_spike_time), .nrn_spike_ack(nrn_spike_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_time(out_time), .busy(busy),
    .cfg_err(cfg_err)
  );

  pn_scheduler #(.N_NEURON(5), .IDX_W(3), .TIME_W(16)) dut5 (
    .clk(clk), .rst(rst), .cfg_valid(c5_valid), .cfg_ready(c5_ready), .cfg_idx(c5_idx),
    .cfg_data(c5_data), .cfg_last(c5_last), .start(c5_start), .stop(1'b0), .nrn_en(c5_en),
    .nrn_kill(c5_kill), .nrn_wdata(c5_wdata), .nrn_spike_vld(5'b0),
    .nrn_spike_time(80'b0), .nrn_spike_ack(c5_ack), .out_valid(c5_ov),
    .out_ready(1'b1), .out_idx(c5_oidx), .out_time(c5_otime), .busy(c5_busy),
    .cfg_err(c5_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (0 idle/cfg, 1 run, 2 drain)
  int          m_st = 0;
  bit          m_ov = 0;
  int          m_oidx = 0;
  logic [15:0] m_otime = '0;
  int          m_rr = 0;
  logic [15:0] m_cnt = '0;
  logic [3:0]  m_loaded = '0;
  bit          pend[N];
  logic [15:0] ptime[N];

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   data;
    logic          last;
    logic          exp_busy;
  } cfg_vec_t;
  cfg_vec_t cv[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with somas driven from pend/ptime; checks ack pre-edge and outputs post-edge.
  task automatic run_cycle(input bit rdy, input bit sta, input bit stp);
    logic [N-1:0] v;
    int           win;
    bit           ov_before;
    logic [3:0]   kill_exp;
    for (int i = 0; i < N; i++) begin
      v[i] = pend[i];
      nrn_spike_time[16*i +: 16] = ptime[i];
    end
    nrn_spike_vld = v;
    out_ready     = rdy;
    start         = sta;
    stop          = stp;
    #1;
    win = -1;
    if (m_st == 1 && (!m_ov || rdy)) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(m_rr + k) % N]) win = (m_rr + k) % N;
      end
    end
    chk("ack", 64'(nrn_spike_ack), (win >= 0) ? (64'd1 << win) : 64'd0);
    tick();
    start     = 1'b0;
    stop      = 1'b0;
    ov_before = m_ov;
    if (win >= 0) begin
      m_ov   = 1;
      m_oidx = win;
`ifdef PN_SCHED_TIMESTAMP_EN
      m_otime = ptime[win] + m_cnt;
`else
      m_otime = ptime[win];
`endif
      m_rr       = (win + 1) % N;
      pend[win]  = 0;
    end else if (rdy) begin
      m_ov = 0;
    end
    kill_exp = (m_st == 1 && stp) ? m_loaded : 4'h0;
    case (m_st)
      0: if (sta && m_loaded != 0) begin m_st = 1; m_cnt = '0; end
      1: begin m_cnt = m_cnt + 16'd1; if (stp) m_st = 2; end
      2: if (!ov_before) m_st = 0;
      default: m_st = 0;
    endcase
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_idx", 64'(out_idx), 64'(m_oidx));
      chk("out_time", 64'(out_time), 64'(m_otime));
    end
    chk("nrn_en", 64'(nrn_en), (m_st == 1) ? 64'(m_loaded) : 64'd0);
    chk("nrn_kill", 64'(nrn_kill), 64'(kill_exp));
    chk("busy", 64'(busy), 64'(m_st != 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i]  = 0;
      ptime[i] = '0;
      cv[i].idx      = IW'(i);
      cv[i].data     = 32'h0A050308 + 32'(i);
      cv[i].last     = (i == 3);
      cv[i].exp_busy = (i != 3);
    end

    // Reset state
    #3;
    chk("rst cfg_ready", 64'(cfg_ready), 0);
    chk("rst outputs", 64'({busy, out_valid, cfg_err, nrn_en, nrn_kill, nrn_spike_ack}), 0);
    chk("rst wdata", nrn_wdata[63:0], 0);
    tick();
    rst = 1'b1;
    tick();
    chk("idle cfg_ready", 64'(cfg_ready), 1);

    // Out-of-range config index on the 5-slot instance
    c5_valid = 1; c5_idx = 3'd1; c5_data = 32'h11111111; c5_last = 0;
    tick();
    c5_idx = 3'd5; c5_data = 32'hDEADBEEF; c5_last = 1;
    tick();
    c5_valid = 0; c5_last = 0;
    chk("c5 cfg_err", 64'(c5_err), 1);
    chk("c5 busy", 64'(c5_busy), 0);
    for (int i = 0; i < 5; i++)
      chk("c5 wdata", 64'(c5_wdata[32*i +: 32]), (i == 1) ? 64'h11111111 : 64'd0);
    tick();
    chk("c5 cfg_err sticky", 64'(c5_err), 1);
    c5_start = 1;
    tick();
    c5_start = 0;
    chk("c5 nrn_en", 64'(c5_en), 64'h02);

    // Start with nothing loaded is ignored
    run_cycle(1, 1, 0);

    // Config table
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1; cfg_idx = cv[i].idx; cfg_data = cv[i].data; cfg_last = cv[i].last;
      #1;
      chk("cfg_ready", 64'(cfg_ready), 1);
      tick();
      chk("cfg busy", 64'(busy), 64'(cv[i].exp_busy));
    end
    cfg_valid = 0; cfg_last = 0;
    for (int i = 0; i < 4; i++) chk("wdata", 64'(nrn_wdata[32*i +: 32]), 64'(cv[i].data));
    chk("cfg_err clean", 64'(cfg_err), 0);
    m_loaded = 4'hF;

    run_cycle(1, 1, 0);
    chk("run en", 64'(nrn_en), 64'hF);
    chk("run cfg_ready", 64'(cfg_ready), 0);

    // All four pending at once: consecutive grants in index order
    for (int i = 0; i < N; i++) begin pend[i] = 1; ptime[i] = 16'(10 * (i + 1)); end
    for (int i = 0; i < N; i++) begin
      run_cycle(1, 0, 0);
      chk("rr order", 64'(out_idx), 64'(i));
    end
    run_cycle(1, 0, 0);
    // Pointer wrapped: slot 0 beats slot 3
    pend[0] = 1; pend[3] = 1; ptime[0] = 16'h0100; ptime[3] = 16'h0300;
    run_cycle(1, 0, 0);
    chk("wrap idx", 64'(out_idx), 0);
    run_cycle(1, 0, 0);
    run_cycle(1, 0, 0);

    // Back-pressure holds the output and blocks further grants
    pend[2] = 1; ptime[2] = 16'h0222;
    run_cycle(0, 0, 0);
    pend[1] = 1; ptime[1] = 16'h0111;
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 0);
      chk("stall idx", 64'(out_idx), 2);
    end
    run_cycle(1, 0, 0);
    chk("release idx", 64'(out_idx), 1);

    // Stop with an event buffered
    pend[3] = 1; ptime[3] = 16'h0333;
    run_cycle(0, 0, 1);
    chk("stop kill", 64'(nrn_kill), 64'hF);
    run_cycle(0, 0, 0);
    chk("kill pulse", 64'(nrn_kill), 0);
    run_cycle(0, 1, 0);
    run_cycle(1, 0, 0);
    chk("drain busy", 64'(busy), 1);
    run_cycle(1, 0, 0);
    chk("drain done", 64'(busy), 0);
    pend[3] = 0;

`ifdef PN_SCHED_TIMESTAMP_EN
    run_cycle(1, 1, 0);
    for (int i = 0; i < 32; i++) run_cycle(1, 0, 0);
    pend[1] = 1; ptime[1] = 16'hFFF0;
    run_cycle(1, 0, 0);
    chk("stamp wrap", 64'(out_time), 64'h0010);
    run_cycle(1, 0, 1);
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 0);
`endif

    // Random traffic against the model
    run_cycle(1, 1, 0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i]  = 1;
          ptime[i] = 16'($urandom);
        end
      end
      run_cycle($urandom_range(3) != 0, 0, 0);
    end
    run_cycle(0, 0, 1);
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int i = 0; i < 4; i++) run_cycle(1, 0, 0);
    chk("rand idle", 64'(busy), 0);

    // Reset mid-run drops the buffered event and the loaded mask
    run_cycle(1, 1, 0);
    pend[0] = 1; ptime[0] = 16'h0ABC;
    run_cycle(0, 0, 0);
    chk("pre-rst valid", 64'(out_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid-rst outputs", 64'({out_valid, busy, nrn_en}), 0);
    tick();
    rst = 1'b1;
    m_st = 0; m_ov = 0; m_rr = 0; m_loaded = '0; pend[0] = 0;
    run_cycle(1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
